// File: rtl/rf_window_sequencer.sv
// rf_window_sequencer: image store plus FSM that streams consecutive 16-pixel windows
// of the stored frame into a downstream FIFO, stalling while the FIFO is full.
module rf_window_sequencer #(
    parameter int IMG_PIXELS  = 784,
    parameter int STEP        = 16,
    parameter int NUM_WINDOWS = 49
) (
    input  logic         clk1,
    input  logic         reset_an1,
    input  logic         img_wr_en,
    input  logic [9:0]   img_wr_addr,
    input  logic [7:0]   img_wr_data,
    input  logic         start,
    input  logic         fifo_full,
    output logic [127:0] pattern_out,
    output logic         pattern_valid,
    output logic [5:0]   window_idx,
    output logic         busy,
    output logic         done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state;
    logic [7:0]   mem [IMG_PIXELS];
    logic [9:0]   base;
    logic [127:0] win;

    assign base          = 10'(window_idx) * 10'(STEP);
    assign busy          = state == FETCH || state == EMIT;
    assign done          = state == DONE;
    assign pattern_valid = state == EMIT && !fifo_full;

    // First pixel of the window lands in the most significant byte.
    for (genvar i = 0; i < STEP; i++) begin : g_win
        assign win[8*(STEP-1-i) +: 8] = mem[base + 10'(i)];
    end

    // The store has no reset so an image survives an aborted frame.
    always_ff @(posedge clk1)
        if (img_wr_en && !busy && img_wr_addr < 10'(IMG_PIXELS))
            mem[img_wr_addr] <= img_wr_data;

    always_ff @(posedge clk1 or negedge reset_an1)
        if (!reset_an1) begin
            state       <= IDLE;
            pattern_out <= '0;
            window_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= FETCH;
                    window_idx <= '0;
                end
                FETCH: begin
                    pattern_out <= win;
                    state       <= EMIT;
                end
                EMIT: if (!fifo_full) begin
                    if (window_idx < 6'(NUM_WINDOWS - 1)) begin
                        window_idx <= window_idx + 6'd1;
                        state      <= FETCH;
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    window_idx <= '0;
                end
            endcase
        end
endmodule

// File: tb/tb_rf_window_sequencer.sv
// tb_rf_window_sequencer: transfer-level reference model of the window stream with
// randomized FIFO back-pressure, busy-time noise and a mid-frame reset.
module tb_rf_window_sequencer;
    logic         clk1 = 0;
    logic         reset_an1 = 0;
    logic         img_wr_en = 0;
    logic [9:0]   img_wr_addr = 0;
    logic [7:0]   img_wr_data = 0;
    logic         start = 0;
    logic         fifo_full = 0;
    logic [127:0] pattern_out;
    logic         pattern_valid;
    logic [5:0]   window_idx;
    logic         busy;
    logic         done;

    rf_window_sequencer dut (
        .clk1(clk1), .reset_an1(reset_an1), .img_wr_en(img_wr_en),
        .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data), .start(start),
        .fifo_full(fifo_full), .pattern_out(pattern_out), .pattern_valid(pattern_valid),
        .window_idx(window_idx), .busy(busy), .done(done)
    );

    always #5 clk1 = ~clk1;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a frame is a list of windows, each fetched once then offered
    // until the FIFO accepts it; a one-cycle done follows the last accepted window.
    logic [7:0]   mem_m [784];
    bit           frame_on = 0;
    bit           loaded = 0;
    bit           done_exp = 0;
    int           next_win = 0;
    logic [127:0] exp_pat = 0;
    int           cyc = 0;
    int           start_cyc = 0;

    always @(posedge clk1 or negedge reset_an1) begin
        if (!reset_an1) begin
            frame_on = 0;
            loaded   = 0;
            done_exp = 0;
        end else begin
            cyc++;
            if (img_wr_en && !frame_on && img_wr_addr < 784) mem_m[img_wr_addr] = img_wr_data;
            if (done_exp) done_exp = 0;
            else if (frame_on) begin
                if (!loaded) begin
                    for (int j = 0; j < 16; j++) exp_pat[127-8*j -: 8] = mem_m[next_win*16 + j];
                    loaded = 1;
                end else if (!fifo_full) begin
                    loaded = 0;
                    if (next_win == 48) begin
                        frame_on = 0;
                        done_exp = 1;
                    end else next_win++;
                end
            end else if (start) begin
                frame_on  = 1;
                next_win  = 0;
                loaded    = 0;
                start_cyc = cyc;
            end
        end
    end

    logic [127:0] cap [49];
    int           xfer [49];
    int           done_cnt = 0;
    bit           timed = 0;

    always @(negedge clk1) if (reset_an1) begin
        chk("busy", busy, frame_on);
        chk("pattern_valid", pattern_valid, frame_on && loaded && !fifo_full);
        chk("done", done, done_exp);
        if (frame_on) chk("window_idx", window_idx, next_win);
        else if (!done_exp) chk("window_idx_idle", window_idx, 0);
        if (frame_on && loaded) chk("pattern_out", pattern_out, exp_pat);
        if (pattern_valid && window_idx < 49) begin
            cap[window_idx] = pattern_out;
            xfer[window_idx]++;
        end
        if (done) begin
            done_cnt++;
            if (timed) chk("done_latency", cyc - start_cyc, 98);
        end
    end

    task automatic tick;
        @(posedge clk1);
        #2;
    endtask

    task automatic wr(input int addr, input int data);
        img_wr_en   = 1;
        img_wr_addr = 10'(addr);
        img_wr_data = 8'(data);
        tick;
        img_wr_en = 0;
    endtask

    task automatic run_frame(input int pct, input bit noise, input int stall_at, input bit timed_in);
        int n0 = done_cnt;
        int budget = 0;
        int ones = 0;
        bit stalled = 0;
        for (int w = 0; w < 49; w++) xfer[w] = 0;
        timed = timed_in;
        start = 1;
        tick;
        start = 0;
        while (done_cnt == n0 && budget < 3000) begin
            if (stall_at >= 0 && !stalled && frame_on && loaded && next_win == stall_at) begin
                start     = 0;
                img_wr_en = 0;
                fifo_full = 1;
                repeat (10) tick;
                chk("stall_window_idx", window_idx, 6'(stall_at));
                chk("stall_valid", pattern_valid, 0);
                chk("stall_pattern", pattern_out, 128'h505152535455565758595A5B5C5D5E5F);
                stalled = 1;
            end
            fifo_full = $urandom_range(0, 99) < pct;
            if (noise && frame_on) begin
                start       = 1'($urandom_range(0, 1));
                img_wr_en   = 1'($urandom_range(0, 1));
                img_wr_addr = 10'($urandom_range(0, 1023));
                img_wr_data = 8'($urandom);
            end else begin
                start     = 0;
                img_wr_en = 0;
            end
            tick;
            budget++;
        end
        start     = 0;
        img_wr_en = 0;
        fifo_full = 0;
        timed     = 0;
        chk("frame_done_in_budget", 128'(done_cnt != n0), 1);
        for (int w = 0; w < 49; w++) if (xfer[w] == 1) ones++;
        chk("one_transfer_per_window", ones, 49);
        tick;
    endtask

    initial begin
        repeat (2) tick;
        chk("reset_pattern", pattern_out, 0);
        chk("reset_idx", window_idx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", pattern_valid, 0);
        chk("reset_done", done, 0);
        reset_an1 = 1;
        tick;

        for (int i = 0; i < 784; i++) wr(i, i % 256);
        wr(784, 8'hFF);
        for (int i = 0; i < 8; i++) wr($urandom_range(785, 1023), $urandom);

        run_frame(0, 0, -1, 1);
        chk("ramp_window0", cap[0], 128'h000102030405060708090A0B0C0D0E0F);
        chk("ramp_window1", cap[1], 128'h101112131415161718191A1B1C1D1E1F);
        chk("ramp_window48", cap[48], 128'h000102030405060708090A0B0C0D0E0F);

        run_frame(0, 1, 5, 0);
        chk("noise_window0", cap[0], 128'h000102030405060708090A0B0C0D0E0F);
        chk("noise_window47", cap[47], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

        for (int w = 0; w < 49; w++) xfer[w] = 0;
        start = 1;
        tick;
        start = 0;
        for (int b = 0; b < 500 && !(frame_on && next_win == 20); b++) tick;
        chk("reached_window20", next_win, 20);
        #1 reset_an1 = 0;
        #1;
        chk("async_reset_pattern", pattern_out, 0);
        chk("async_reset_idx", window_idx, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_valid", pattern_valid, 0);
        chk("async_reset_done", done, 0);
        repeat (2) tick;
        reset_an1 = 1;
        repeat (3) tick;
        run_frame(0, 0, -1, 1);
        chk("after_reset_window0", cap[0], 128'h000102030405060708090A0B0C0D0E0F);

        for (int i = 0; i < 784; i++) wr(i, $urandom);
        run_frame(40, 1, -1, 0);
        run_frame(75, 0, -1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
